// File: rtl/button_bank.sv
// Multi-channel button debouncer with edge pulses and optional auto-repeat.
// Define BUTTON_BANK_REPEAT_EN to build the repeat counters; otherwise rpt is tied to 0.
module button_bank #(
  parameter int CHANNELS      = 5,
  parameter int STABLE_CYCLES = 650000,
  parameter int REPEAT_DELAY  = 32500000,
  parameter int REPEAT_PERIOD = 6500000
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic [CHANNELS-1:0] noisy,
  output logic [CHANNELS-1:0] clean,
  output logic [CHANNELS-1:0] rise,
  output logic [CHANNELS-1:0] fall,
  output logic [CHANNELS-1:0] rpt,
  output logic                any_held
);

  localparam int              CNT_W    = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  if (CHANNELS < 1 || CHANNELS > 16) begin : g_chk_channels
    $error("button_bank: CHANNELS must be 1..16");
  end
  if (STABLE_CYCLES < 2 || REPEAT_DELAY < 2 || REPEAT_PERIOD < 2) begin : g_chk_timing
    $error("button_bank: STABLE_CYCLES, REPEAT_DELAY and REPEAT_PERIOD must be >= 2");
  end

  logic [CHANNELS-1:0]            sync1_q, sync2_q;
  logic [CHANNELS-1:0]            clean_q, clean_d;
  logic [CHANNELS-1:0]            rise_q, rise_d;
  logic [CHANNELS-1:0]            fall_q, fall_d;
  logic [CHANNELS-1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic                           any_held_q;

  // The stability counter only runs while the synchronized level disagrees with clean.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    clean_d = clean_q;
    rise_d  = '0;
    fall_d  = '0;
    cnt_d   = cnt_q;
    for (int i = 0; i < CHANNELS; i++) begin
      if (sync2_q[i] == clean_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_LAST) begin
        cnt_d[i]   = '0;
        clean_d[i] = sync2_q[i];
        rise_d[i]  = sync2_q[i];
        fall_d[i]  = ~sync2_q[i];
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      clean_q    <= '0;
      rise_q     <= '0;
      fall_q     <= '0;
      cnt_q      <= '0;
      any_held_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments let every flop sample pre-edge values, which is what
      // makes the two synchronizer stages a real two-cycle pipeline.
      sync1_q    <= noisy;
      sync2_q    <= sync1_q;
      clean_q    <= clean_d;
      rise_q     <= rise_d;
      fall_q     <= fall_d;
      cnt_q      <= cnt_d;
      any_held_q <= |clean_q;
    end
  end

  assign clean    = clean_q;
  assign rise     = rise_q;
  assign fall     = fall_q;
  assign any_held = any_held_q;

`ifdef BUTTON_BANK_REPEAT_EN
  localparam int               RPT_MAX     = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY
                                                                            : REPEAT_PERIOD;
  localparam int               RPT_W       = $clog2(RPT_MAX);
  localparam logic [RPT_W-1:0] DELAY_LAST  = RPT_W'(REPEAT_DELAY - 1);
  localparam logic [RPT_W-1:0] PERIOD_LAST = RPT_W'(REPEAT_PERIOD - 1);

  logic [CHANNELS-1:0][RPT_W-1:0] rcnt_q, rcnt_d;
  logic [CHANNELS-1:0]            armed_q, armed_d;
  logic [CHANNELS-1:0]            rpt_q, rpt_d;

  // armed marks that the first (long) delay has elapsed; afterwards the counter wraps per period.
  always_comb begin
    rcnt_d  = rcnt_q;
    armed_d = armed_q;
    rpt_d   = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (rise_d[i] || fall_d[i] || !clean_q[i]) begin
        rcnt_d[i]  = '0;
        armed_d[i] = 1'b0;
      end else if (rcnt_q[i] == (armed_q[i] ? PERIOD_LAST : DELAY_LAST)) begin
        rcnt_d[i]  = '0;
        armed_d[i] = 1'b1;
        rpt_d[i]   = 1'b1;
      end else begin
        rcnt_d[i] = rcnt_q[i] + RPT_W'(1);
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rcnt_q  <= '0;
      armed_q <= '0;
      rpt_q   <= '0;
    end else begin
      rcnt_q  <= rcnt_d;
      armed_q <= armed_d;
      rpt_q   <= rpt_d;
    end
  end

  assign rpt = rpt_q;
`else
  assign rpt = '0;
`endif

endmodule

// File: tb/tb_button_bank.sv
// Self-checking bench for button_bank: directed scenarios plus random noise against a
// history-window reference model. Works with or without BUTTON_BANK_REPEAT_EN.
module tb_button_bank;

  localparam int CH = 3;
  localparam int S  = 4;
  localparam int D  = 10;
  localparam int P  = 3;
  localparam int OW = 4 * CH + 1;

  logic          clock   = 1'b0;
  logic          reset_n = 1'b0;
  logic [CH-1:0] noisy   = '0;
  logic [CH-1:0] clean, rise, fall, rpt;
  logic          any_held;

  int errors = 0;
  int checks = 0;

  button_bank #(
    .CHANNELS     (CH),
    .STABLE_CYCLES(S),
    .REPEAT_DELAY (D),
    .REPEAT_PERIOD(P)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .noisy   (noisy),
    .clean   (clean),
    .rise    (rise),
    .fall    (fall),
    .rpt     (rpt),
    .any_held(any_held)
  );

  always #5 clock = ~clock;

  // Reference model: clean flips when the S samples taken 2..S+1 edges ago all differ from it.
  logic [S+1:0]  hist [CH];
  logic [CH-1:0] clean_m, rise_m, fall_m, rpt_m;
  logic          anyh_m;
  int            t_rise [CH];
  int            edge_n = 0;

  function automatic logic exp_rpt(input int k);
`ifdef BUTTON_BANK_REPEAT_EN
    return (k >= D) && (((k - D) % P) == 0);
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [OW-1:0] obs_vec();
    return {clean, rise, fall, rpt, any_held};
  endfunction

  function automatic logic [OW-1:0] exp_vec();
    return {clean_m, rise_m, fall_m, rpt_m, anyh_m};
  endfunction

  task automatic model_reset();
    clean_m = '0;
    rise_m  = '0;
    fall_m  = '0;
    rpt_m   = '0;
    anyh_m  = 1'b0;
    for (int c = 0; c < CH; c++) begin
      hist[c]   = '0;
      t_rise[c] = 0;
    end
  endtask

  task automatic model_edge();
    anyh_m = |clean_m;
    rise_m = '0;
    fall_m = '0;
    rpt_m  = '0;
    for (int c = 0; c < CH; c++) begin
      hist[c] = {hist[c][S:0], noisy[c]};
      if (hist[c][S+1:2] == {S{~clean_m[c]}}) begin
        clean_m[c] = ~clean_m[c];
        if (clean_m[c]) begin
          rise_m[c] = 1'b1;
          t_rise[c] = edge_n;
        end else begin
          fall_m[c] = 1'b1;
        end
      end else if (clean_m[c]) begin
        rpt_m[c] = exp_rpt(edge_n - t_rise[c]);
      end
    end
    edge_n++;
  endtask

  task automatic step();
    @(posedge clock);
    model_edge();
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    noisy   = CH'($urandom);
    repeat (3) @(posedge clock);
    #1;
    checks++;
    if (obs_vec() !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got %b expected %b", obs_vec(), {OW{1'b0}});
    end
    noisy   = '0;
    model_reset();
    reset_n = 1'b1;
    for (int e = 1; e <= 8; e++) begin
      step();
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL reset_idle e=%0d: got %b expected %b", e, obs_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_latency();
    noisy[0] = 1'b1;
    for (int e = 1; e <= 7; e++) begin
      logic [1:0] want;
      step();
      want = (e < 6) ? 2'b00 : (e == 6) ? 2'b11 : 2'b10;
      checks++;
      if ({clean[0], rise[0]} !== want) begin
        errors++;
        $display("FAIL latency e=%0d: got clean/rise %b expected %b", e, {clean[0], rise[0]}, want);
      end
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL latency_model e=%0d: got %b expected %b", e, obs_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_glitch();
    noisy[1] = 1'b1;
    for (int e = 1; e <= 14; e++) begin
      step();
      if (e == 3) noisy[1] = 1'b0;
      checks++;
      if ({clean[1], rise[1], fall[1], rpt[1]} !== 4'b0000) begin
        errors++;
        $display("FAIL glitch e=%0d: got %b expected 0000", e, {clean[1], rise[1], fall[1], rpt[1]});
      end
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL glitch_model e=%0d: got %b expected %b", e, obs_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_repeat();
    noisy[2] = 1'b1;
    for (int e = 1; e <= 6; e++) begin
      step();
      checks++;
      if (rise[2] !== (e == 6)) begin
        errors++;
        $display("FAIL repeat_rise e=%0d: got %b expected %b", e, rise[2], (e == 6));
      end
    end
    for (int k = 1; k <= 30; k++) begin
      step();
      checks++;
      if (rpt[2] !== exp_rpt(k)) begin
        errors++;
        $display("FAIL repeat_rpt k=%0d: got %b expected %b", k, rpt[2], exp_rpt(k));
      end
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL repeat_model k=%0d: got %b expected %b", k, obs_vec(), exp_vec());
      end
    end
    noisy[2] = 1'b0;
    for (int e = 1; e <= 10; e++) begin
      logic want_rpt;
      step();
      want_rpt = (e < 6) ? exp_rpt(30 + e) : 1'b0;
      checks++;
      if ({fall[2], rpt[2]} !== {(e == 6), want_rpt}) begin
        errors++;
        $display("FAIL release e=%0d: got fall/rpt %b expected %b", e, {fall[2], rpt[2]},
                 {(e == 6), want_rpt});
      end
    end
  endtask

  task automatic test_simultaneous();
    noisy = '0;
    for (int e = 1; e <= 8; e++) begin
      step();
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL idle_model e=%0d: got %b expected %b", e, obs_vec(), exp_vec());
      end
    end
    noisy = 3'b101;
    for (int e = 1; e <= 7; e++) begin
      step();
      checks++;
      if ({rise, any_held} !== {((e == 6) ? 3'b101 : 3'b000), (e == 7)}) begin
        errors++;
        $display("FAIL simultaneous e=%0d: got rise/any_held %b expected %b", e, {rise, any_held},
                 {((e == 6) ? 3'b101 : 3'b000), (e == 7)});
      end
    end
  endtask

  task automatic test_reset_mid();
    noisy = 3'b010;
    for (int e = 1; e <= 6; e++) step();
    checks++;
    if (clean[1] !== 1'b1) begin
      errors++;
      $display("FAIL mid_setup: got clean[1]=%b expected 1", clean[1]);
    end
    reset_n = 1'b0;
    #1;
    checks++;
    if (obs_vec() !== '0) begin
      errors++;
      $display("FAIL mid_reset_now: got %b expected %b", obs_vec(), {OW{1'b0}});
    end
    @(posedge clock);
    #1;
    checks++;
    if (obs_vec() !== '0) begin
      errors++;
      $display("FAIL mid_reset_hold: got %b expected %b", obs_vec(), {OW{1'b0}});
    end
    model_reset();
    reset_n = 1'b1;
    for (int e = 1; e <= 7; e++) begin
      step();
      checks++;
      if ({rise[1], fall} !== {(e == 6), 3'b000}) begin
        errors++;
        $display("FAIL mid_release e=%0d: got rise1/fall %b expected %b", e, {rise[1], fall},
                 {(e == 6), 3'b000});
      end
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL mid_model e=%0d: got %b expected %b", e, obs_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 3000; n++) begin
      int unsigned odds;
      odds = ((n / 200) % 2 == 0) ? 8 : 60;
      for (int c = 0; c < CH; c++)
        if ($urandom_range(odds - 1, 0) == 0) noisy[c] = ~noisy[c];
      step();
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL random n=%0d: got %b expected %b", n, obs_vec(), exp_vec());
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_latency();
    test_glitch();
    test_repeat();
    test_simultaneous();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
